// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding command to AXI4-Lite master bridge; zero-wait latency is accept N -> rsp_valid N+3.
// Backpressure: cmd_ready is low from acceptance until the cycle after the response handshake.
module axi4_lite_cmd_master #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDRESS-1:0]      cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDRESS-1:0]      M_AWADDR,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  output logic [ADDRESS-1:0]      M_ARADDR,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RVALID,
  output logic                    M_RREADY
);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA, RSP} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDRESS-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    aw_done;
  logic                    w_done;
  logic                    cmd_acc;
  logic                    misaligned;

  assign cmd_acc    = cmd_valid && cmd_ready;
  assign misaligned = (cmd_addr[1:0] != 2'b00);

  assign M_AWADDR = addr_q;
  assign M_ARADDR = addr_q;
  assign M_WDATA  = wdata_q;
  assign M_WSTRB  = wstrb_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    M_AWVALID = 1'b0;
    M_WVALID  = 1'b0;
    M_BREADY  = 1'b0;
    M_ARVALID = 1'b0;
    M_RREADY  = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !ARESET;
        if (cmd_valid && !ARESET)
          state_nxt = misaligned ? RSP : (cmd_write ? WR : RADDR);
      end
      WR: begin
        // Each channel drops its VALID independently once its own handshake is recorded.
        M_AWVALID = !aw_done;
        M_WVALID  = !w_done;
        if ((aw_done || M_AWREADY) && (w_done || M_WREADY)) state_nxt = WRESP;
      end
      WRESP: begin
        M_BREADY = 1'b1;
        if (M_BVALID) state_nxt = RSP;
      end
      RADDR: begin
        M_ARVALID = 1'b1;
        if (M_ARREADY) state_nxt = RDATA;
      end
      RDATA: begin
        M_RREADY = 1'b1;
        if (M_RVALID) state_nxt = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      if (cmd_acc) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (misaligned) begin
          rsp_rdata <= '0;
          rsp_resp  <= 2'b10;
        end
      end
      if (M_AWVALID && M_AWREADY) aw_done <= 1'b1;
      if (M_WVALID && M_WREADY)   w_done  <= 1'b1;
      if (state == WRESP && M_BVALID) begin
        rsp_rdata <= '0;
        rsp_resp  <= M_BRESP;
      end
      if (state == RDATA && M_RVALID) begin
        rsp_rdata <= M_RDATA;
        rsp_resp  <= M_RRESP;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Bench for axi4_lite_cmd_master: memory-backed AXI4-Lite slave with adjustable stalls,
// array reference model filling a scoreboard, and a decoupled response/protocol monitor.
module tb_axi4_lite_cmd_master;

  logic        ACLK;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
  logic [3:0]  M_WSTRB;
  logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
  logic [1:0]  M_BRESP, M_RRESP;
  logic        M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

  axi4_lite_cmd_master #(.ADDRESS(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [64];
  logic [31:0] smem[64];
  int total = 0, bad = 0, cyc = 0;
  int acc_cyc, aw_hs_cyc, w_hs_cyc, rsp_first_cyc, rsp_hs_cyc;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, rsp_cnt = 0;
  int aw_hi = 0, w_hi = 0, arv_hi = 0, stall_cnt = 0;
  int exp_wr = 0, exp_rd = 0, abandoned = 0;
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0, rsp_hold = 0;
  bit rnd = 0;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [1:0] slave_resp(input logic [31:0] a);
    return (a[7:2] == 6'd13) ? 2'b10 : 2'b00;
  endfunction

  function automatic int next_wait();
    return rnd ? int'($urandom_range(0, 3)) : 0;
  endfunction

  // AXI4-Lite slave: readies and beats are chosen at the falling edge for the next rising edge.
  logic [31:0] aw_a, w_d, ar_a;
  logic [3:0]  w_s;
  bit aw_have, w_have, ar_have, b_hs, r_hs;
  initial begin
    M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = 0;
    M_ARREADY = 0; M_RVALID = 0; M_RDATA = 0; M_RRESP = 0; rsp_ready = 1;
    aw_have = 0; w_have = 0; ar_have = 0; b_hs = 0; r_hs = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_ARREADY = 0; M_RVALID = 0;
        aw_have = 0; w_have = 0; ar_have = 0; b_hs = 0; r_hs = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        continue;
      end
      if (b_hs) begin M_BVALID = 0; b_hs = 0; end
      if (r_hs) begin M_RVALID = 0; r_hs = 0; end
      if (aw_have && w_have && !M_BVALID) begin
        if (b_wait > 0) b_wait--;
        else begin
          for (int b = 0; b < 4; b++)
            if (w_s[b]) smem[aw_a[7:2]][8*b +: 8] = w_d[8*b +: 8];
          M_BVALID = 1; M_BRESP = slave_resp(aw_a);
          aw_have = 0; w_have = 0; b_wait = next_wait();
        end
      end
      if (M_BVALID && M_BREADY) begin b_hs = 1; b_cnt++; end
      M_AWREADY = 0;
      if (M_AWVALID) aw_hi++;
      if (M_AWVALID && !aw_have) begin
        if (aw_wait > 0) aw_wait--;
        else begin
          M_AWREADY = 1; aw_have = 1; aw_a = M_AWADDR; aw_cnt++; aw_hs_cyc = cyc;
          aw_wait = next_wait();
        end
      end
      M_WREADY = 0;
      if (M_WVALID) w_hi++;
      if (M_WVALID && !w_have) begin
        if (w_wait > 0) w_wait--;
        else begin
          M_WREADY = 1; w_have = 1; w_d = M_WDATA; w_s = M_WSTRB; w_cnt++; w_hs_cyc = cyc;
          w_wait = next_wait();
        end
      end
      if (ar_have && !M_RVALID) begin
        if (r_wait > 0) r_wait--;
        else begin
          M_RVALID = 1; M_RDATA = smem[ar_a[7:2]]; M_RRESP = slave_resp(ar_a);
          ar_have = 0; r_wait = next_wait();
        end
      end
      if (M_RVALID && M_RREADY) begin r_hs = 1; r_cnt++; end
      M_ARREADY = 0;
      if (M_ARVALID) arv_hi++;
      if (M_ARVALID && !ar_have) begin
        if (ar_wait > 0) ar_wait--;
        else begin
          M_ARREADY = 1; ar_have = 1; ar_a = M_ARADDR; ar_cnt++; ar_wait = next_wait();
        end
      end
      if (rsp_hold > 0 && rsp_valid) begin
        rsp_ready = 0; rsp_hold--;
      end else begin
        rsp_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: response scoreboard plus VALID/payload stability while stalled.
  initial begin
    logic        p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_rd, p_awa, p_wd, p_ara;
    logic [1:0]  p_rs;
    logic [3:0]  p_ws;
    exp_t e;
    p_rv = 0; p_rr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    p_rd = 0; p_awa = 0; p_wd = 0; p_ara = 0; p_rs = 0; p_ws = 0;
    forever begin
      @(negedge ACLK);
      #1;
      if (ARESET) begin
        p_rv = 0; p_awv = 0; p_wv = 0; p_arv = 0;
        continue;
      end
      if (rsp_valid && !p_rv) rsp_first_cyc = cyc;
      if (p_rv && !p_rr) begin
        total++;
        if (!rsp_valid || rsp_rdata !== p_rd || rsp_resp !== p_rs) begin
          bad++;
          $display("FAIL rsp_hold: got valid=%0b data=%08h resp=%0b required valid=1 data=%08h resp=%0b",
                   rsp_valid, rsp_rdata, rsp_resp, p_rd, p_rs);
        end
      end
      if (rsp_valid) chk("cmd_ready_during_rsp", {31'd0, cmd_ready}, 32'd0);
      if (rsp_valid && !rsp_ready) stall_cnt++;
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        rsp_hs_cyc = cyc;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: got data=%08h resp=%0b required no response", rsp_rdata, rsp_resp);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, e.resp});
        end
      end
      if (p_awv && !p_awr) begin
        total++;
        if (!M_AWVALID || M_AWADDR !== p_awa) begin
          bad++;
          $display("FAIL aw_stable: got valid=%0b addr=%08h required valid=1 addr=%08h", M_AWVALID, M_AWADDR, p_awa);
        end
      end
      if (p_wv && !p_wr) begin
        total++;
        if (!M_WVALID || M_WDATA !== p_wd || M_WSTRB !== p_ws) begin
          bad++;
          $display("FAIL w_stable: got valid=%0b data=%08h required valid=1 data=%08h", M_WVALID, M_WDATA, p_wd);
        end
      end
      if (p_arv && !p_arr) begin
        total++;
        if (!M_ARVALID || M_ARADDR !== p_ara) begin
          bad++;
          $display("FAIL ar_stable: got valid=%0b addr=%08h required valid=1 addr=%08h", M_ARVALID, M_ARADDR, p_ara);
        end
      end
      p_rv = rsp_valid; p_rr = rsp_ready; p_rd = rsp_rdata; p_rs = rsp_resp;
      p_awv = M_AWVALID; p_awr = M_AWREADY; p_awa = M_AWADDR;
      p_wv = M_WVALID; p_wr = M_WREADY; p_wd = M_WDATA; p_ws = M_WSTRB;
      p_arv = M_ARVALID; p_arr = M_ARREADY; p_ara = M_ARADDR;
    end
  end

  // Issue one command; on acceptance the reference model predicts its response.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int   n;
    exp_t e;
    n = 0;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 300) begin
      @(negedge ACLK);
      n++;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL cmd_accept_timeout: got cmd_ready=0 required acceptance within 300 cycles");
      cmd_valid = 0;
      return;
    end
    acc_cyc = cyc;
    if (a[1:0] != 2'b00) begin
      e.rdata = 32'd0; e.resp = 2'b10;
    end else if (w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[a[7:2]][8*b +: 8] = d[8*b +: 8];
      e.rdata = 32'd0; e.resp = (a[7:2] == 6'd13) ? 2'b10 : 2'b00;
      exp_wr++;
    end else begin
      e.rdata = mdl[a[7:2]]; e.resp = (a[7:2] == 6'd13) ? 2'b10 : 2'b00;
      exp_rd++;
    end
    sb.push_back(e);
    @(posedge ACLK);
    #1 cmd_valid = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge ACLK);
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL rsp_timeout: got %0d responses outstanding required 0", sb.size());
    end
  endtask

  initial begin
    int b0, a0, v0, st0, r0, seen, n;
    logic        w, mis;
    logic [31:0] a;
    for (int i = 0; i < 64; i++) begin
      mdl[i]  = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
      smem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    end
    ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    repeat (3) @(negedge ACLK);
    #1;
    chk("reset_ctrl_outputs", {25'd0, cmd_ready, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    @(negedge ACLK);
    ARESET = 0;
    #1 chk("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // Zero-wait write: AW/W one cycle after accept, response three cycles after.
    send(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF);
    wait_done();
    chk("wr_aw_latency", aw_hs_cyc - acc_cyc, 32'd1);
    chk("wr_w_latency", w_hs_cyc - acc_cyc, 32'd1);
    chk("wr_rsp_latency", rsp_first_cyc - acc_cyc, 32'd3);

    send(1'b0, 32'h0000_0008, 32'd0, 4'h0);
    wait_done();
    chk("rd_araddr", ar_a, 32'h0000_0008);
    chk("rd_rsp_latency", rsp_first_cyc - acc_cyc, 32'd3);

    // AWREADY held off three cycles while WREADY is immediate.
    aw_wait = 3; aw_hi = 0; w_hi = 0; b0 = b_cnt;
    send(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011);
    wait_done();
    chk("awvalid_cycles", aw_hi, 32'd4);
    chk("wvalid_cycles", w_hi, 32'd1);
    chk("b_handshakes", b_cnt - b0, 32'd1);

    // Misaligned read never reaches the bus.
    a0 = ar_cnt; v0 = arv_hi;
    send(1'b0, 32'h0000_0006, 32'd0, 4'h0);
    wait_done();
    chk("misaligned_ar_hs", ar_cnt - a0, 32'd0);
    chk("misaligned_arvalid", arv_hi - v0, 32'd0);

    // Response stalled five cycles; next command waits for the release.
    rsp_hold = 5; st0 = stall_cnt;
    send(1'b0, 32'h0000_0008, 32'd0, 4'h0);
    send(1'b1, 32'h0000_0014, 32'h0BAD_F00D, 4'b1100);
    chk("second_cmd_after_rsp", acc_cyc - rsp_hs_cyc, 32'd1);
    chk("rsp_stall_cycles", stall_cnt - st0, 32'd5);
    wait_done();

    // Reset while waiting on the write response abandons the transaction.
    b_wait = 30;
    send(1'b1, 32'h0000_0080, 32'hCAFE_F00D, 4'hF);
    n = 0;
    while (!M_BREADY && n < 50) begin
      @(negedge ACLK);
      #1;
      n++;
    end
    chk("reached_wresp", {31'd0, M_BREADY}, 32'd1);
    ARESET = 1;
    #1;
    chk("arst_ctrl_outputs", {25'd0, cmd_ready, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}, 32'd0);
    chk("arst_rsp_rdata", rsp_rdata, 32'd0);
    sb.delete();
    abandoned++;
    r0 = rsp_cnt; seen = 0;
    repeat (2) @(negedge ACLK);
    ARESET = 0;
    repeat (5) begin
      @(negedge ACLK);
      #1;
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_arst", seen, 32'd0);
    chk("no_rsp_hs_after_arst", rsp_cnt - r0, 32'd0);
    send(1'b0, 32'h0000_0008, 32'd0, 4'h0);
    wait_done();

    // Randomized traffic with random slave stalls and response backpressure.
    rnd = 1;
    for (int i = 0; i < 150; i++) begin
      w   = 1'($urandom_range(0, 1));
      mis = ($urandom_range(0, 7) == 0);
      a   = {24'd0, 4'($urandom_range(0, 15)), 2'b00};
      if (mis) a[1:0] = 2'($urandom_range(1, 3));
      send(w, a, $urandom, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(negedge ACLK);
    end
    wait_done();
    rnd = 0;
    repeat (4) @(negedge ACLK);

    chk("aw_count", aw_cnt, exp_wr);
    chk("w_count", w_cnt, exp_wr);
    chk("b_count", b_cnt, exp_wr - abandoned);
    chk("ar_count", ar_cnt, exp_rd);
    chk("r_count", r_cnt, exp_rd);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
